sha256_block_ctrl: RTL

Sequencing controller for the SHA-256 compression datapath in the uPcoin hasher. It accepts one pre-padded 512-bit block per handshake and runs the 64 compression rounds, one round per clock. It generates the message schedule with a 16-word sliding window instead of a fully unrolled W[0:63] array, and accumulates the chaining value H0..H7 across blocks. It sits between the block loader (SPI front end) and the result path of uPcoin_core.

---
 rtl/sha256_pkg.sv | 45 ++++
 rtl/sha256_funcs.sv | 58 +++++
 rtl/sha256_round.sv | 42 ++++
 rtl/sha256_block_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 block controller: round constants,
// initial hash value, working-state layout and the controller state enum.
package sha256_pkg;

    localparam int WORD    = 32;
    localparam int NWIN    = 16;
    localparam int NROUND  = 64;
    localparam int BLOCK_W = WORD * NWIN;
    localparam int HASH_W  = WORD * 8;

    typedef logic [WORD-1:0] word_t;
    // Element [7] is a / H0 so the packed vector reads {H0..H7} from the top bits down.
    typedef logic [7:0][WORD-1:0] hstate_t;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

    localparam hstate_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t K [NROUND] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD - n));
    endfunction

endpackage

// File: rtl/sha256_funcs.sv
// SHA-256 bitwise primitives: Ch, Maj, the round sigmas and the schedule sigmas.
module sha256_ch
    import sha256_pkg::*;
(
    input  word_t x_i,
    input  word_t y_i,
    input  word_t z_i,
    output word_t r_o
);
    assign r_o = (x_i & y_i) ^ (~x_i & z_i);
endmodule

module sha256_maj
    import sha256_pkg::*;
(
    input  word_t x_i,
    input  word_t y_i,
    input  word_t z_i,
    output word_t r_o
);
    assign r_o = (x_i & y_i) ^ (x_i & z_i) ^ (y_i & z_i);
endmodule

module sha256_bsig0
    import sha256_pkg::*;
(
    input  word_t x_i,
    output word_t r_o
);
    assign r_o = rotr(x_i, 2) ^ rotr(x_i, 13) ^ rotr(x_i, 22);
endmodule

module sha256_bsig1
    import sha256_pkg::*;
(
    input  word_t x_i,
    output word_t r_o
);
    assign r_o = rotr(x_i, 6) ^ rotr(x_i, 11) ^ rotr(x_i, 25);
endmodule

module sha256_ssig0
    import sha256_pkg::*;
(
    input  word_t x_i,
    output word_t r_o
);
    assign r_o = rotr(x_i, 7) ^ rotr(x_i, 18) ^ (x_i >> 3);
endmodule

module sha256_ssig1
    import sha256_pkg::*;
(
    input  word_t x_i,
    output word_t r_o
);
    assign r_o = rotr(x_i, 17) ^ rotr(x_i, 19) ^ (x_i >> 10);
endmodule

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: (a..h, W, K) -> next a..h.
module sha256_round
    import sha256_pkg::*;
(
    input  word_t a_i,
    input  word_t b_i,
    input  word_t c_i,
    input  word_t d_i,
    input  word_t e_i,
    input  word_t f_i,
    input  word_t g_i,
    input  word_t h_i,
    input  word_t w_i,
    input  word_t k_i,
    output word_t a_o,
    output word_t b_o,
    output word_t c_o,
    output word_t d_o,
    output word_t e_o,
    output word_t f_o,
    output word_t g_o,
    output word_t h_o
);
    word_t big_s0, big_s1, ch, maj, t1, t2;

    sha256_bsig0 u_bsig0 (.x_i(a_i), .r_o(big_s0));
    sha256_bsig1 u_bsig1 (.x_i(e_i), .r_o(big_s1));
    sha256_ch    u_ch    (.x_i(e_i), .y_i(f_i), .z_i(g_i), .r_o(ch));
    sha256_maj   u_maj   (.x_i(a_i), .y_i(b_i), .z_i(c_i), .r_o(maj));

    assign t1 = h_i + big_s1 + ch + k_i + w_i;
    assign t2 = big_s0 + maj;

    assign a_o = t1 + t2;
    assign b_o = a_i;
    assign c_o = b_i;
    assign d_o = c_i;
    assign e_o = d_i + t1;
    assign f_o = e_i;
    assign g_o = f_i;
    assign h_o = g_i;
endmodule

// File: rtl/sha256_block_ctrl.sv
// SHA-256 block sequencer: accepts a padded 512-bit block, runs 64 rounds at one
// per clock with a 16-word sliding schedule window, and chains H across blocks.
module sha256_block_ctrl
    import sha256_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               block_valid,
    output logic               block_ready,
    input  logic [BLOCK_W-1:0] block,
    input  logic               first_block,
    output logic               busy,
    output logic               hash_valid,
    output logic [HASH_W-1:0]  hash
);
    state_e     state_q, state_d;
    logic [5:0] t_q;
    word_t      w_q [NWIN];
    word_t      w_next [NWIN];
    hstate_t    h_q, v_q, round_out, h_sum;
    logic       hash_valid_q;
    logic       accept;
    word_t      ssig0_out, ssig1_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        block_ready = 1'b0;
        busy        = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                block_ready = 1'b1;
                if (block_valid) begin
                    accept  = 1'b1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                busy = 1'b1;
                if (t_q == 6'(NROUND - 1)) state_d = FINAL;
            end
            FINAL: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    sha256_ssig0 u_ssig0 (.x_i(w_q[1]),  .r_o(ssig0_out));
    sha256_ssig1 u_ssig1 (.x_i(w_q[14]), .r_o(ssig1_out));

    // Window slides one word per round; the new tail word is W[t+16].
    for (genvar gi = 0; gi < NWIN - 1; gi++) begin : g_shift
        assign w_next[gi] = w_q[gi+1];
    end
    assign w_next[NWIN-1] = ssig1_out + w_q[9] + ssig0_out + w_q[0];

    for (genvar gi = 0; gi < 8; gi++) begin : g_hsum
        assign h_sum[gi] = h_q[gi] + v_q[gi];
    end

    sha256_round u_round (
        .a_i(v_q[7]), .b_i(v_q[6]), .c_i(v_q[5]), .d_i(v_q[4]),
        .e_i(v_q[3]), .f_i(v_q[2]), .g_i(v_q[1]), .h_i(v_q[0]),
        .w_i(w_q[0]), .k_i(K[t_q]),
        .a_o(round_out[7]), .b_o(round_out[6]), .c_o(round_out[5]), .d_o(round_out[4]),
        .e_o(round_out[3]), .f_o(round_out[2]), .g_o(round_out[1]), .h_o(round_out[0])
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q          <= IV;
            v_q          <= '0;
            t_q          <= '0;
            hash_valid_q <= 1'b0;
            for (int i = 0; i < NWIN; i++) w_q[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < NWIN; i++) w_q[i] <= block[WORD*i +: WORD];
            if (first_block) begin
                h_q <= IV;
                v_q <= IV;
            end else begin
                v_q <= h_q;
            end
            t_q          <= '0;
            hash_valid_q <= 1'b0;
        end else if (state_q == ROUND) begin
            v_q <= round_out;
            t_q <= t_q + 6'd1;
            for (int i = 0; i < NWIN; i++) w_q[i] <= w_next[i];
        end else if (state_q == FINAL) begin
            h_q          <= h_sum;
            hash_valid_q <= 1'b1;
        end
    end

    assign hash_valid = hash_valid_q;
    assign hash       = h_q;

endmodule
